// File: rtl/psram_qpi_pkg.sv
// Command opcodes and responder FSM states shared by the PSRAM QPI responder and its controller.
package psram_qpi_pkg;

    localparam logic [7:0] CMD_RSTEN    = 8'h66;
    localparam logic [7:0] CMD_RST      = 8'h99;
    localparam logic [7:0] CMD_SPI2QPI  = 8'h35;
    localparam logic [7:0] CMD_READ     = 8'hEB;
    localparam logic [7:0] CMD_WRITE    = 8'h38;
    localparam logic [7:0] CMD_QPI_EXIT = 8'hF5;

    typedef enum logic [2:0] {
        StIdle,
        StSpiCmd,
        StQpiCmd,
        StQpiAddr,
        StQpiWdata,
        StQpiWait,
        StQpiRdata,
        StIgnore
    } state_t;

endpackage

// File: rtl/psram_model_ram.sv
// Simple dual-port 16-bit word RAM with registered read, intended to map onto block RAM.
module psram_model_ram #(
    parameter int unsigned ADDR_W = 10
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [15:0]       wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [15:0]       rdata
);

    logic [15:0] mem [0:(1 << ADDR_W) - 1];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
        if (re) rdata <= mem[raddr];
    end

endmodule

// File: rtl/psram_qpi_responder.sv
// LY68L6400-style PSRAM responder: SPI init commands, then QPI fast-read / quad-write bursts
// against an internal word RAM.
module psram_qpi_responder
    import psram_qpi_pkg::*;
#(
    parameter int unsigned ADDR_W      = 10,
    parameter int unsigned WAIT_CYCLES = 6
) (
    input  logic       mem_clk,
    input  logic       rst_n,
    input  logic       mem_ce,
    input  logic [3:0] mem_sio_in,
    output logic [3:0] mem_sio_out,
    output logic       mem_sio_oe,
    output logic       qpi_mode,
    output logic [7:0] last_cmd,
    output logic       cmd_error
);

    localparam logic [7:0] WaitLast = 8'(WAIT_CYCLES - 1);

    state_t              state, state_nx;
    logic [19:0]         shreg;
    logic [7:0]          cnt;
    logic [ADDR_W-1:0]   idx;
    logic                is_write, rst_armed;
    logic [7:0]          byte_in;
    logic [23:0]         addr_in;
    logic                decode, restart_cnt, ram_we, rd_en;
    logic [ADDR_W-1:0]   rd_addr;
    logic [15:0]         rd_data;
    logic                unused;

    assign byte_in = qpi_mode ? {shreg[3:0], mem_sio_in} : {shreg[6:0], mem_sio_in[0]};
    assign addr_in = {shreg, mem_sio_in};
    // Address bits above the RAM depth alias onto the same words.
    assign unused  = ^addr_in[23:ADDR_W];

    always_ff @(posedge mem_clk or negedge rst_n) begin
        if (!rst_n) state <= StIdle;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        if (mem_ce) begin
            state_nx = StIdle;
        end else begin
            unique case (state)
                StIdle:     state_nx = qpi_mode ? StQpiCmd : StSpiCmd;
                StSpiCmd:   if (cnt == 8'd7) state_nx = StIgnore;
                StQpiCmd:   state_nx = (byte_in == CMD_READ || byte_in == CMD_WRITE) ?
                                       StQpiAddr : StIgnore;
                StQpiAddr:  if (cnt == 8'd7) state_nx = is_write ? StQpiWdata : StQpiWait;
                StQpiWait:  if (cnt == WaitLast) state_nx = StQpiRdata;
                StQpiWdata: state_nx = StQpiWdata;
                StQpiRdata: state_nx = StQpiRdata;
                StIgnore:   state_nx = StIgnore;
            endcase
        end
    end

    always_comb begin
        decode      = !mem_ce && ((state == StSpiCmd && cnt == 8'd7) || state == StQpiCmd);
        restart_cnt = (state == StQpiAddr || state == StQpiWait) && state_nx != state;
        ram_we      = !mem_ce && state == StQpiWdata && cnt[1:0] == 2'd3;
        // First word is fetched on the last wait cycle, later words on each word's last nibble.
        rd_en       = !mem_ce && ((state == StQpiWait && cnt == WaitLast) ||
                                  (state == StQpiRdata && cnt[1:0] == 2'd3));
        rd_addr     = (state == StQpiRdata) ? idx + 1'b1 : idx;
    end

    always_ff @(posedge mem_clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg     <= '0;
            cnt       <= '0;
            idx       <= '0;
            is_write  <= 1'b0;
            qpi_mode  <= 1'b0;
            rst_armed <= 1'b0;
            last_cmd  <= '0;
            cmd_error <= 1'b0;
        end else begin
            cmd_error <= 1'b0;
            if (mem_ce) begin
                cnt <= '0;
                if (state == StQpiWdata && cnt[1:0] != 2'd0) cmd_error <= 1'b1;
            end else begin
                shreg <= qpi_mode ? {shreg[15:0], mem_sio_in} : {shreg[18:0], mem_sio_in[0]};
                cnt   <= restart_cnt ? '0 : cnt + 8'd1;
                if (decode) begin
                    last_cmd <= byte_in;
                    is_write <= (byte_in == CMD_WRITE);
                    case (byte_in)
                        CMD_RSTEN: rst_armed <= 1'b1;
                        CMD_RST: begin
                            if (rst_armed) begin
                                qpi_mode  <= 1'b0;
                                rst_armed <= 1'b0;
                            end else begin
                                cmd_error <= 1'b1;
                            end
                        end
                        CMD_SPI2QPI: begin
                            if (!qpi_mode) qpi_mode <= 1'b1;
                            else           cmd_error <= 1'b1;
                        end
                        CMD_READ, CMD_WRITE: if (!qpi_mode) cmd_error <= 1'b1;
                        CMD_QPI_EXIT: begin
                            if (qpi_mode) qpi_mode <= 1'b0;
                            else          cmd_error <= 1'b1;
                        end
                        default: cmd_error <= 1'b1;
                    endcase
                end
                if (state == StQpiAddr && cnt == 8'd7) idx <= addr_in[ADDR_W-1:0];
                if ((state == StQpiWdata || state == StQpiRdata) && cnt[1:0] == 2'd3) begin
                    idx <= idx + 1'b1;
                end
            end
        end
    end

    psram_model_ram #(
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk   (mem_clk),
        .we    (ram_we),
        .waddr (idx),
        .wdata ({shreg[11:0], mem_sio_in}),
        .re    (rd_en),
        .raddr (rd_addr),
        .rdata (rd_data)
    );

    // Read nibbles launch on the falling edge so the controller samples them mid-cycle.
    always_ff @(negedge mem_clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_sio_oe  <= 1'b0;
            mem_sio_out <= '0;
        end else begin
            mem_sio_oe <= (state == StQpiRdata) && qpi_mode;
            if (state == StQpiRdata) begin
                unique case (cnt[1:0])
                    2'd0: mem_sio_out <= rd_data[15:12];
                    2'd1: mem_sio_out <= rd_data[11:8];
                    2'd2: mem_sio_out <= rd_data[7:4];
                    2'd3: mem_sio_out <= rd_data[3:0];
                endcase
            end else begin
                mem_sio_out <= '0;
            end
        end
    end

endmodule

// File: tb/tb_psram_qpi_responder.sv
// Directed bench for psram_qpi_responder: a driver issues SPI/QPI transactions and queues the
// expected read nibbles; a monitor compares them (with cycle index) whenever oe is high.
module tb_psram_qpi_responder;
    import psram_qpi_pkg::*;

    localparam int unsigned ADDR_W = 10;
    localparam int unsigned WAIT   = 6;

    typedef struct {
        int         k;
        logic [3:0] nib;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ce = 1'b1;
    logic [3:0] sio = 4'h0;
    logic [3:0] sio_out;
    logic       oe;
    logic       qpi;
    logic [7:0] last_cmd;
    logic       cmd_err;

    int   tests = 0;
    int   fails = 0;
    int   err_seen = 0;
    int   kcnt = 0;
    exp_t exp_q[$];

    psram_qpi_responder #(
        .ADDR_W      (ADDR_W),
        .WAIT_CYCLES (WAIT)
    ) dut (
        .mem_clk     (clk),
        .rst_n       (rst_n),
        .mem_ce      (ce),
        .mem_sio_in  (sio),
        .mem_sio_out (sio_out),
        .mem_sio_oe  (oe),
        .qpi_mode    (qpi),
        .last_cmd    (last_cmd),
        .cmd_error   (cmd_err)
    );

    always #5 clk = ~clk;

    // Read-data monitor: outputs change on negedge, so sample on posedge.
    always @(posedge clk) begin
        exp_t e;
        if (ce) begin
            kcnt = 0;
        end else begin
            if (oe) begin
                tests++;
                if (exp_q.size() == 0) begin
                    fails++;
                    $display("FAIL unexpected_oe: got oe=1 nib=%h at k%0d, required oe=0",
                             sio_out, kcnt);
                end else begin
                    e = exp_q.pop_front();
                    if (e.k != kcnt || e.nib !== sio_out) begin
                        fails++;
                        $display("FAIL read_nibble: got %h at k%0d, required %h at k%0d",
                                 sio_out, kcnt, e.nib, e.k);
                    end
                end
            end
            kcnt = kcnt + 1;
        end
    end

    // cmd_error is a posedge-launched pulse; count it on the opposite edge.
    always @(negedge clk) begin
        if (cmd_err === 1'b1) err_seen++;
    end

    task automatic check(input string name, input logic [15:0] got, input logic [15:0] req);
        tests++;
        if (got !== req) begin
            fails++;
            $display("FAIL %s: got %h, required %h", name, got, req);
        end
    endtask

    task automatic drive(input logic [3:0] n);
        @(negedge clk);
        ce  = 1'b0;
        sio = n;
    endtask

    task automatic end_txn();
        @(negedge clk);
        ce  = 1'b1;
        sio = 4'h0;
        repeat (2) @(negedge clk);
    endtask

    task automatic spi_cmd(input logic [7:0] c);
        for (int i = 7; i >= 0; i--) drive({3'b000, c[i]});
        end_txn();
    endtask

    task automatic qpi_cmd(input logic [7:0] c);
        drive(c[7:4]);
        drive(c[3:0]);
        end_txn();
    endtask

    task automatic qpi_hdr(input logic [7:0] c, input logic [23:0] a);
        drive(c[7:4]);
        drive(c[3:0]);
        for (int i = 5; i >= 0; i--) drive(a[i*4 +: 4]);
    endtask

    task automatic put_word(input logic [15:0] w);
        for (int i = 3; i >= 0; i--) drive(w[i*4 +: 4]);
    endtask

    // Expected word at burst position widx; first nibble is valid at posedge k8+WAIT.
    task automatic expect_word(input logic [15:0] w, input int widx);
        for (int j = 0; j < 4; j++) begin
            exp_q.push_back('{k: 8 + WAIT + 4 * widx + j, nib: w[(3 - j) * 4 +: 4]});
            drive(4'h0);
        end
    endtask

    task automatic wait_cycles();
        repeat (WAIT) drive(4'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, required $finish");
        $fatal(1, "timeout");
    end

    initial begin
        int e0;
        // Reset state.
        repeat (3) @(negedge clk);
        check("rst_qpi_mode", {15'd0, qpi}, 16'd0);
        check("rst_last_cmd", {8'd0, last_cmd}, 16'd0);
        check("rst_oe", {15'd0, oe}, 16'd0);
        check("rst_sio_out", {12'd0, sio_out}, 16'd0);
        check("rst_cmd_error", {15'd0, cmd_err}, 16'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // 1: SPI init sequence.
        e0 = err_seen;
        spi_cmd(CMD_RSTEN);
        check("spi_66_last_cmd", {8'd0, last_cmd}, 16'h0066);
        spi_cmd(CMD_RST);
        check("spi_99_qpi_mode", {15'd0, qpi}, 16'd0);
        spi_cmd(CMD_SPI2QPI);
        check("spi_35_qpi_mode", {15'd0, qpi}, 16'd1);
        check("spi_35_last_cmd", {8'd0, last_cmd}, 16'h0035);
        check("spi_init_no_error", 16'(err_seen - e0), 16'd0);

        // 2: single-word write then read, with exact first-nibble timing.
        qpi_hdr(CMD_WRITE, 24'h000012);
        put_word(16'hABCD);
        end_txn();
        check("write_last_cmd", {8'd0, last_cmd}, 16'h0038);
        qpi_hdr(CMD_READ, 24'h000012);
        wait_cycles();
        expect_word(16'hABCD, 0);
        end_txn();
        // Bits 23 and 10 are outside the RAM index and must alias.
        qpi_hdr(CMD_READ, 24'h800412);
        wait_cycles();
        expect_word(16'hABCD, 0);
        end_txn();

        // 3: write burst wrapping from the top word, then reads across the wrap.
        qpi_hdr(CMD_WRITE, 24'h0003FF);
        put_word(16'h1111);
        put_word(16'h2222);
        put_word(16'h3333);
        end_txn();
        qpi_hdr(CMD_READ, 24'h000001);
        wait_cycles();
        expect_word(16'h3333, 0);
        end_txn();
        qpi_hdr(CMD_READ, 24'h0003FF);
        wait_cycles();
        expect_word(16'h1111, 0);
        expect_word(16'h2222, 1);
        expect_word(16'h3333, 2);
        end_txn();

        // 4: aborted partial write word.
        qpi_hdr(CMD_WRITE, 24'h000020);
        put_word(16'h5A5A);
        end_txn();
        e0 = err_seen;
        qpi_hdr(CMD_WRITE, 24'h000020);
        drive(4'h1);
        drive(4'h2);
        end_txn();
        check("partial_write_error", 16'(err_seen - e0), 16'd1);
        qpi_hdr(CMD_READ, 24'h000020);
        wait_cycles();
        expect_word(16'h5A5A, 0);
        end_txn();

        // 5: QPI reset handshake.
        e0 = err_seen;
        qpi_cmd(CMD_RST);
        check("unarmed_rst_error", 16'(err_seen - e0), 16'd1);
        check("unarmed_rst_qpi_mode", {15'd0, qpi}, 16'd1);
        e0 = err_seen;
        qpi_cmd(CMD_RSTEN);
        qpi_cmd(CMD_RST);
        check("armed_rst_qpi_mode", {15'd0, qpi}, 16'd0);
        check("armed_rst_last_cmd", {8'd0, last_cmd}, 16'h0099);
        check("armed_rst_no_error", 16'(err_seen - e0), 16'd0);

        // 6: async reset in the middle of a read burst.
        spi_cmd(CMD_SPI2QPI);
        check("reinit_qpi_mode", {15'd0, qpi}, 16'd1);
        qpi_hdr(CMD_READ, 24'h000012);
        wait_cycles();
        exp_q.push_back('{k: 8 + WAIT, nib: 4'hA});
        exp_q.push_back('{k: 9 + WAIT, nib: 4'hB});
        repeat (2) drive(4'h0);
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("midburst_rst_oe", {15'd0, oe}, 16'd0);
        check("midburst_rst_qpi_mode", {15'd0, qpi}, 16'd0);
        ce = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        spi_cmd(CMD_SPI2QPI);
        qpi_hdr(CMD_READ, 24'h000012);
        wait_cycles();
        expect_word(16'hABCD, 0);
        end_txn();
        qpi_hdr(CMD_READ, 24'h000020);
        wait_cycles();
        expect_word(16'h5A5A, 0);
        end_txn();

        check("pending_expectations", 16'(exp_q.size()), 16'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
